// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-master APB3 bridge from the CPU data-memory port
// to the peripheral bus.
//   PCLK, PRESET       clock, asynchronous active-high reset
//   transfer/write/addr/wdata   one-cycle host request
//   rdata/ready/error  completion pulse back to the host
//   PADDR/PWRITE/PWDATA/PENABLE/PSEL   APB master outputs
//   PRDATA_bus/PREADY_bus   concatenated per-slave responses
// Slave i lives at 0x1000_0000 + i*0x1000 (4 KB windows).

// Per-slave decode: asserts hit for its own window and gates its response so
// the top can OR-reduce without any out-of-range indexing.
module apb_master_bridge_slv #(
  parameter int IDX = 0
) (
  input  logic [3:0]  idx,
  input  logic        mapped,
  input  logic [31:0] prdata,
  input  logic        pready,
  output logic        hit,
  output logic [31:0] prdata_g,
  output logic        pready_g
);
  assign hit      = mapped && (idx == 4'(IDX));
  assign prdata_g = hit ? prdata : '0;
  assign pready_g = hit & pready;
endmodule

module apb_master_bridge #(
  parameter int NUM_SLV     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    error,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [32*NUM_SLV-1:0]   PRDATA_bus,
  input  logic [NUM_SLV-1:0]      PREADY_bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic [7:0] cnt;
  logic       tmo;
  logic       mapped;
  logic       latch;

  logic [NUM_SLV-1:0]       hit;
  logic [NUM_SLV-1:0]       pready_g;
  logic [NUM_SLV-1:0][31:0] prdata_g;
  logic                     pready_sel;
  logic [31:0]              prdata_sel;

  // Decode always works on the latched address, never the live host bus.
  assign mapped = (PADDR[31:16] == 16'h1000) && ({28'd0, PADDR[15:12]} < NUM_SLV);
  assign tmo    = (cnt == 8'(TIMEOUT_CYC - 1));

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_slv
    apb_master_bridge_slv #(.IDX(g)) u_slv (
      .idx      (PADDR[15:12]),
      .mapped   (mapped),
      .prdata   (PRDATA_bus[32*g +: 32]),
      .pready   (PREADY_bus[g]),
      .hit      (hit[g]),
      .prdata_g (prdata_g[g]),
      .pready_g (pready_g[g])
    );
  end

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) prdata_sel = prdata_sel | prdata_g[i];
  end
  assign pready_sel = |pready_g;

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (ready) state_nxt = transfer ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: all combinational from state so reset drops PSEL/PENABLE at once.
  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    ready   = 1'b0;
    error   = 1'b0;
    rdata   = '0;
    case (state)
      SETUP:  PSEL = hit;
      ACCESS: begin
        PSEL    = hit;
        PENABLE = 1'b1;
        if (!mapped) begin
          ready = 1'b1;
          error = 1'b1;
        end else if (pready_sel) begin
          ready = 1'b1;
          rdata = PWRITE ? 32'd0 : prdata_sel;
        end else if (tmo) begin
          ready = 1'b1;
          error = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Requests are accepted only when idle or in the completion cycle.
  assign latch = transfer && ((state == IDLE) || ready);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
    end else if (latch) begin
      PADDR  <= addr;
      PWDATA <= wdata;
      PWRITE <= write;
    end
  end

  // Counts ACCESS cycles spent waiting on PREADY.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                        cnt <= '0;
    else if (state == SETUP)           cnt <= '0;
    else if (state == ACCESS && !ready) cnt <= cnt + 8'd1;
  end

endmodule
